// File: rtl/column_loader_pkg.sv
// Shared types and column-geometry helpers for the serial column loader harness.
package column_loader_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, CAPTURE} state_t;

    function automatic int C(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int TOTAL(input int n);
        return n * n;
    endfunction

    // Column i of an n x n partial-product array holds min(i+1, 2n-1-i) bits.
    function automatic int col_height(input int n, input int i);
        return (i + 1 < 2 * n - 1 - i) ? i + 1 : 2 * n - 1 - i;
    endfunction

    function automatic int col_offset(input int n, input int i);
        int s;
        s = 0;
        for (int j = 0; j < i; j++) s += col_height(n, j);
        return s;
    endfunction

endpackage

// File: rtl/column_loader_harness_col_shift_reg.sv
// One column's shift register: new bit enters at the LSB, the MSB falls off.
module col_shift_reg #(
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             din,
    output logic [DEPTH-1:0] q
);

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (rst)        q <= '0;
                else if (shift) q <= din;
            end
        end else begin : g_many
            always_ff @(posedge clk) begin
                if (rst)        q <= '0;
                else if (shift) q <= {q[DEPTH-2:0], din};
            end
        end
    endgenerate

endmodule

// File: rtl/column_loader_harness.sv
// Serial-load harness for an N x N partial-product compressor: loads 2N-1 columns, waits, captures.
// Define REF_CHECK_EN to compare the compressor output against a built-in popcount reference.
module column_loader_harness
    import column_loader_pkg::*;
#(
    parameter int N       = 9,
    parameter int LATENCY = 0,
    parameter int OUT_W   = 2 * N + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [C(N)-1:0]     src_in,
    output logic [TOTAL(N)-1:0] col_bits,
    input  logic [OUT_W-1:0]    dst_in,
    output logic                busy,
    output logic                done,
    output logic [OUT_W-1:0]    result,
    output logic                mismatch
);

    localparam int NC = C(N);
    localparam int BW = $clog2(N + 1);
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t          state, state_nxt;
    logic [BW-1:0]   beat_cnt;
    logic [LW-1:0]   wait_cnt;
    logic            shift;
    logic            cap;
    logic            ref_miss;

    always_comb begin
        state_nxt = state;
        shift     = 1'b0;
        cap       = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD: begin
                if (in_valid) begin
                    shift = 1'b1;
                    if (beat_cnt == BW'(N - 1))
                        state_nxt = (LATENCY > 0) ? WAIT : CAPTURE;
                end
            end
            WAIT:    if (wait_cnt == LW'(LATENCY - 1)) state_nxt = CAPTURE;
            CAPTURE: begin
                cap       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            wait_cnt <= '0;
            done     <= 1'b0;
            result   <= '0;
            mismatch <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= cap;
            if (state == IDLE) beat_cnt <= '0;
            else if (shift)    beat_cnt <= beat_cnt + BW'(1);
            if (state == WAIT) wait_cnt <= wait_cnt + LW'(1);
            else               wait_cnt <= '0;
            if (cap) begin
                result   <= dst_in;
                mismatch <= ref_miss;
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef REF_CHECK_EN
    logic [OUT_W-1:0] col_w [NC];
    logic [OUT_W-1:0] ref_sum;
`endif

    for (genvar i = 0; i < NC; i++) begin : g_col
        localparam int H   = col_height(N, i);
        localparam int OFF = col_offset(N, i);
        logic [H-1:0] q;

        col_shift_reg #(.DEPTH(H)) u_col (
            .clk   (clk),
            .rst   (rst),
            .shift (shift),
            .din   (src_in[i]),
            .q     (q)
        );

        assign col_bits[OFF +: H] = q;

`ifdef REF_CHECK_EN
        logic [OUT_W-1:0] pc;
        always_comb begin
            pc = '0;
            for (int b = 0; b < H; b++) pc = pc + OUT_W'(q[b]);
        end
        assign col_w[i] = pc << i;
`endif
    end

`ifdef REF_CHECK_EN
    // Columns hold still through WAIT/CAPTURE, so the reference is stable at the capture edge.
    always_comb begin
        ref_sum = '0;
        for (int i = 0; i < NC; i++) ref_sum = ref_sum + col_w[i];
    end
    assign ref_miss = (ref_sum != dst_in);
`else
    assign ref_miss = 1'b0;
`endif

endmodule
